// File: rtl/tetris_pkg.sv
// Shared types for the Tetris display/game-timing blocks.
// Used here by the round-robin incrementer arbiter.
package tetris_pkg;

    typedef enum logic {GRANT_R0, GRANT_R1} grant_t;

    localparam int INCR_REQ_N = 2;

endpackage

// File: rtl/incr_share_arbiter_if.sv
// Request/ack bus between the two requesters and the shared incrementer arbiter.
interface incr_share_arbiter_if #(parameter int WIDTH = 4);

    logic             req0;
    logic [WIDTH-1:0] val0;
    logic             req1;
    logic [WIDTH-1:0] val1;
    logic             ack0;
    logic             ack1;
    logic [WIDTH-1:0] res;
    logic             wrap;

    modport master (output req0, val0, req1, val1,
                    input  ack0, ack1, res, wrap);

    modport slave  (input  req0, val0, req1, val1,
                    output ack0, ack1, res, wrap);

endinterface

// File: rtl/increment.sv
// WIDTH-bit incrementer; the carry out of the top bit is discarded.
module increment #(parameter int WIDTH = 4) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    assign y = a + WIDTH'(1);

endmodule

// File: rtl/incr_share_arbiter.sv
// Round-robin time-sharing of a single incrementer between two requesters.
// The registered acks plus last_grant act as the IDLE/ACK0/ACK1 state.
module incr_share_arbiter
    import tetris_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    incr_share_arbiter_if.slave  bus
);

    logic [INCR_REQ_N-1:0] ack_q;
    logic [INCR_REQ_N-1:0] ack_d;
    logic [INCR_REQ_N-1:0] elig;
    grant_t                last_grant;
    grant_t                grant;
    logic                  grant_vld;
    logic [WIDTH-1:0]      operand;
    logic [WIDTH-1:0]      sum;
    logic [WIDTH-1:0]      res_q;
    logic                  wrap_q;

    // The only adder in the block works on whichever operand won arbitration.
    increment #(.WIDTH(WIDTH)) u_increment (
        .a (operand),
        .y (sum)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_q      <= '0;
            res_q      <= '0;
            wrap_q     <= 1'b0;
            last_grant <= GRANT_R1;
        end else begin
            ack_q <= ack_d;
            if (grant_vld) begin
                res_q      <= sum;
                wrap_q     <= &operand;
                last_grant <= grant;
            end
        end
    end

    // A requester still in its ack cycle is masked so a held req isn't served twice.
    always_comb begin
        elig      = {bus.req1 & ~ack_q[1], bus.req0 & ~ack_q[0]};
        grant_vld = |elig;
        grant     = GRANT_R0;
        unique case (elig)
            2'b01:   grant = GRANT_R0;
            2'b10:   grant = GRANT_R1;
            2'b11:   grant = (last_grant == GRANT_R0) ? GRANT_R1 : GRANT_R0;
            default: grant = GRANT_R0;
        endcase
        operand = (grant == GRANT_R1) ? bus.val1 : bus.val0;
        ack_d   = '0;
        if (grant_vld) begin
            ack_d = (grant == GRANT_R1) ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        bus.ack0 = ack_q[0];
        bus.ack1 = ack_q[1];
        bus.res  = res_q;
        bus.wrap = wrap_q;
    end

endmodule
